// File: rtl/atmr_mon_pkg.sv
// Shared definitions for the ATMR vote monitor.
//   REP_ORI/REP_MAI/REP_MEN : replica index, also the bit position in err_o/fault_o
//   SEL_SAMPLES             : cnt_sel_i value that selects the accepted-sample counter
//   DEFAULT_WIDTH           : default replica vector width (z0..z9)
//   sat_inc()               : increment that sticks at a caller-supplied maximum
package atmr_mon_pkg;

    localparam int unsigned REP_ORI       = 0;
    localparam int unsigned REP_MAI       = 1;
    localparam int unsigned REP_MEN       = 2;
    localparam int unsigned SEL_SAMPLES   = 3;
    localparam int unsigned DEFAULT_WIDTH = 10;

    // Callers zero-extend into 32 bits and truncate the result back to their own width.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max);
        return (val >= max) ? max : val + 32'd1;
    endfunction

endpackage

// File: rtl/atmr_replica_tracker.sv
// Per-replica statistics: saturating mismatch counter, consecutive-mismatch run-length and
// sticky fault flag.
//   clk, rst : clock, synchronous active-high reset
//   clr      : clear counter, run-length and fault; wins over upd
//   upd      : an accepted sample is being recorded this cycle
//   mis      : that sample's replica disagreed with the vote
//   cnt      : saturating mismatch count
//   fault    : set once PERSIST consecutive mismatches have been recorded
module atmr_replica_tracker
    import atmr_mon_pkg::*;
#(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned PERSIST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             upd,
    input  logic             mis,
    output logic [CNT_W-1:0] cnt,
    output logic             fault
);

    localparam logic [31:0] CntMax = 32'({CNT_W{1'b1}});
    localparam logic [31:0] RunMax = 32'(PERSIST);

    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       run_q, run_d;
    logic             fault_q;

    // Run-length stops at PERSIST so a long mismatch streak cannot wrap the 4-bit field.
    always_comb begin
        run_d = 4'd0;
        if (mis) begin
            run_d = 4'(sat_inc(32'(run_q), RunMax));
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q   <= '0;
            run_q   <= 4'd0;
            fault_q <= 1'b0;
        end else if (upd) begin
            if (mis) begin
                cnt_q <= CNT_W'(sat_inc(32'(cnt_q), CntMax));
            end
            run_q <= run_d;
            if (run_d == 4'(PERSIST)) begin
                fault_q <= 1'b1;
            end
        end
    end

    assign cnt   = cnt_q;
    assign fault = fault_q;

endmodule

// File: rtl/atmr_vote_monitor.sv
// Registered 2-of-3 vote stage for an approximate-TMR circuit, with mismatch statistics.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid / in_ready   : replica sample handshake
//   ori_i, mai_i, men_i   : original and two approximate replica vectors
//   clr_i                 : clear counters and sticky faults (voting unaffected)
//   out_valid / out_ready : voted result handshake
//   z_o                   : bitwise majority vote
//   err_o                 : replicas disagreeing with z_o (bit0 ori, bit1 mai, bit2 men)
//   tri_o                 : no two replicas agree on the full word
//   fault_o               : sticky persistent-mismatch flags, same order as err_o
//   cnt_sel_i / cnt_o     : counter readback (0 ori, 1 mai, 2 men, 3 samples)
module atmr_vote_monitor
    import atmr_mon_pkg::*;
#(
    parameter int unsigned WIDTH   = DEFAULT_WIDTH,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned PERSIST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] ori_i,
    input  logic [WIDTH-1:0] mai_i,
    input  logic [WIDTH-1:0] men_i,
    input  logic             clr_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z_o,
    output logic [2:0]       err_o,
    output logic             tri_o,
    output logic [2:0]       fault_o,
    input  logic [1:0]       cnt_sel_i,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [31:0] CntMax = 32'({CNT_W{1'b1}});

    logic             accept;
    logic [WIDTH-1:0] rep [3];
    logic [WIDTH-1:0] z_d;
    logic [2:0]       err_d;
    logic             tri_d;

    logic             out_valid_q;
    logic [WIDTH-1:0] z_q;
    logic [2:0]       err_q;
    logic             tri_q;
    logic [CNT_W-1:0] samples_q;
    logic [CNT_W-1:0] rep_cnt [3];

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    assign rep[REP_ORI] = ori_i;
    assign rep[REP_MAI] = mai_i;
    assign rep[REP_MEN] = men_i;

    assign z_d   = (ori_i & mai_i) | (ori_i & men_i) | (mai_i & men_i);
    assign tri_d = (ori_i != mai_i) && (ori_i != men_i) && (mai_i != men_i);

    always_comb begin
        err_d = 3'b000;
        for (int k = 0; k < 3; k++) begin
            err_d[k] = (rep[k] != z_d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            z_q         <= '0;
            err_q       <= 3'b000;
            tri_q       <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            z_q         <= z_d;
            err_q       <= err_d;
            tri_q       <= tri_d;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            samples_q <= '0;
        end else if (accept) begin
            samples_q <= CNT_W'(sat_inc(32'(samples_q), CntMax));
        end
    end

    for (genvar k = 0; k < 3; k++) begin : g_rep
        atmr_replica_tracker #(
            .CNT_W   (CNT_W),
            .PERSIST (PERSIST)
        ) u_tracker (
            .clk   (clk),
            .rst   (rst),
            .clr   (clr_i),
            .upd   (accept),
            .mis   (err_d[k]),
            .cnt   (rep_cnt[k]),
            .fault (fault_o[k])
        );
    end

    always_comb begin
        cnt_o = samples_q;
        unique case (cnt_sel_i)
            2'(REP_ORI):     cnt_o = rep_cnt[REP_ORI];
            2'(REP_MAI):     cnt_o = rep_cnt[REP_MAI];
            2'(REP_MEN):     cnt_o = rep_cnt[REP_MEN];
            2'(SEL_SAMPLES): cnt_o = samples_q;
        endcase
    end

    assign out_valid = out_valid_q;
    assign z_o       = z_q;
    assign err_o     = err_q;
    assign tri_o     = tri_q;

endmodule

// File: tb/tb_atmr_vote_monitor.sv
// Self-checking bench for atmr_vote_monitor (4-bit counters so saturation is reachable).
module tb_atmr_vote_monitor;

    localparam int unsigned W    = 10;
    localparam int unsigned CW   = 4;
    localparam int unsigned PS   = 4;
    localparam int          CMAX = (1 << CW) - 1;

    typedef struct packed {
        logic [W-1:0] z;
        logic [2:0]   err;
        logic         t;
    } res_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  ori_i, mai_i, men_i;
    logic          clr_i;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  z_o;
    logic [2:0]    err_o;
    logic          tri_o;
    logic [2:0]    fault_o;
    logic [1:0]    cnt_sel_i;
    logic [CW-1:0] cnt_o;

    int checks = 0;
    int errors = 0;

    res_t exp_q[$];

    // Reference state, advanced once per clock at the falling edge.
    int         m_cnt [4];
    int         m_run [3];
    logic [2:0] m_fault;
    bit         m_ov;
    bit         live = 1'b0;

    always #5 clk = ~clk;

    atmr_vote_monitor #(
        .WIDTH   (W),
        .CNT_W   (CW),
        .PERSIST (PS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ori_i     (ori_i),
        .mai_i     (mai_i),
        .men_i     (men_i),
        .clr_i     (clr_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z_o       (z_o),
        .err_o     (err_o),
        .tri_o     (tri_o),
        .fault_o   (fault_o),
        .cnt_sel_i (cnt_sel_i),
        .cnt_o     (cnt_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Majority by counting ones per bit position.
    function automatic res_t vote(input logic [W-1:0] o, input logic [W-1:0] a,
                                  input logic [W-1:0] n);
        res_t r;
        int   c;
        r = '0;
        for (int b = 0; b < W; b++) begin
            c = int'(o[b]) + int'(a[b]) + int'(n[b]);
            r.z[b] = (c >= 2);
        end
        r.err = {n != r.z, a != r.z, o != r.z};
        r.t   = (o != a) && (o != n) && (a != n);
        return r;
    endfunction

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    always @(negedge clk) begin : model
        res_t r;
        bit   acc;
        if (live) begin
            check("in_ready", 32'(in_ready), 32'(!m_ov || out_ready));
            check("out_valid", 32'(out_valid), 32'(m_ov));
            check("fault_o", 32'(fault_o), 32'(m_fault));
            check("cnt_o", 32'(cnt_o), 32'(m_cnt[cnt_sel_i]));
        end
        if (rst) begin
            for (int k = 0; k < 4; k++) m_cnt[k] = 0;
            for (int k = 0; k < 3; k++) m_run[k] = 0;
            m_fault = 3'b000;
            m_ov    = 1'b0;
            exp_q.delete();
            live    = 1'b1;
        end else begin
            acc = in_valid && (!m_ov || out_ready);
            if (acc) begin
                r = vote(ori_i, mai_i, men_i);
                exp_q.push_back(r);
                m_ov = 1'b1;
                if (!clr_i) begin
                    m_cnt[3] = sat(m_cnt[3] + 1);
                    for (int k = 0; k < 3; k++) begin
                        if (r.err[k]) begin
                            m_cnt[k] = sat(m_cnt[k] + 1);
                            m_run[k] = (m_run[k] + 1 > int'(PS)) ? int'(PS) : m_run[k] + 1;
                        end else begin
                            m_run[k] = 0;
                        end
                        if (m_run[k] == int'(PS)) m_fault[k] = 1'b1;
                    end
                end
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
            if (clr_i) begin
                for (int k = 0; k < 4; k++) m_cnt[k] = 0;
                for (int k = 0; k < 3; k++) m_run[k] = 0;
                m_fault = 3'b000;
            end
        end
    end

    always @(negedge clk) begin : monitor
        res_t e;
        if (live && !rst && out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL result: out_valid=1 with no expected result (t=%0t)", $time);
            end else begin
                e = exp_q[0];
                check("z_o", 32'(z_o), 32'(e.z));
                check("err_o", 32'(err_o), 32'(e.err));
                check("tri_o", 32'(tri_o), 32'(e.t));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] n);
        in_valid = v;
        ori_i    = o;
        mai_i    = a;
        men_i    = n;
    endtask

    task automatic check_all_cnt_zero(input string name);
        for (int s = 0; s < 4; s++) begin
            cnt_sel_i = 2'(s);
            #0.2;
            check(name, 32'(cnt_o), 32'd0);
        end
    endtask

    initial begin
        logic [W-1:0] o, a, n;
        rst       = 1'b1;
        out_ready = 1'b1;
        clr_i     = 1'b0;
        cnt_sel_i = 2'd3;
        drive(1'b0, '0, '0, '0);
        repeat (2) step();
        rst = 1'b0;

        check("reset z_o", 32'(z_o), 32'd0);
        check("reset err_o", 32'(err_o), 32'd0);
        check("reset tri_o", 32'(tri_o), 32'd0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset fault_o", 32'(fault_o), 32'd0);
        check_all_cnt_zero("reset cnt");

        // Agreement
        cnt_sel_i = 2'd3;
        drive(1'b1, 10'h2A5, 10'h2A5, 10'h2A5);
        step();
        drive(1'b0, '0, '0, '0);
        check("agree z_o", 32'(z_o), 32'h2A5);
        check("agree err_o", 32'(err_o), 32'd0);
        check("agree samples", 32'(cnt_o), 32'd1);
        cnt_sel_i = 2'd1;
        #0.5;
        check("agree mai cnt", 32'(cnt_o), 32'd0);

        // Single divergence building to a fault
        drive(1'b1, 10'h2A5, 10'h2A4, 10'h2A5);
        step();
        check("div z_o", 32'(z_o), 32'h2A5);
        check("div err_o", 32'(err_o), 32'b010);
        check("div mai cnt", 32'(cnt_o), 32'd1);
        repeat (2) step();
        check("div fault before 4th", 32'(fault_o), 32'b000);
        step();
        drive(1'b0, '0, '0, '0);
        check("div fault after 4th", 32'(fault_o), 32'b010);
        check("div mai cnt 4", 32'(cnt_o), 32'd4);
        cnt_sel_i = 2'd0;
        #0.5;
        check("div ori cnt", 32'(cnt_o), 32'd0);
        cnt_sel_i = 2'd2;
        #0.5;
        check("div men cnt", 32'(cnt_o), 32'd0);

        // Broken run never reaches PERSIST
        clr_i = 1'b1;
        step();
        clr_i     = 1'b0;
        cnt_sel_i = 2'd1;
        drive(1'b1, 10'h2A5, 10'h2A4, 10'h2A5);
        repeat (3) step();
        drive(1'b1, 10'h2A5, 10'h2A5, 10'h2A5);
        step();
        drive(1'b1, 10'h2A5, 10'h2A4, 10'h2A5);
        repeat (3) step();
        drive(1'b0, '0, '0, '0);
        check("run fault", 32'(fault_o), 32'b000);
        check("run mai cnt", 32'(cnt_o), 32'd6);

        // Backpressure
        clr_i = 1'b1;
        step();
        clr_i     = 1'b0;
        cnt_sel_i = 2'd3;
        out_ready = 1'b0;
        drive(1'b1, 10'h111, 10'h111, 10'h111);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 10'h3C0 + 10'(i), 10'h3C0 + 10'(i), 10'h3C0);
            check("bp in_ready", 32'(in_ready), 32'd0);
            step();
            check("bp z held", 32'(z_o), 32'h111);
        end
        check("bp samples", 32'(cnt_o), 32'd1);
        out_ready = 1'b1;
        drive(1'b1, 10'h0F0, 10'h0F0, 10'h0F0);
        #0.5;
        check("bp release in_ready", 32'(in_ready), 32'd1);
        step();
        check("bp release z_o", 32'(z_o), 32'h0F0);
        check("bp release samples", 32'(cnt_o), 32'd2);

        // Triple disagreement
        drive(1'b1, 10'h001, 10'h002, 10'h004);
        step();
        drive(1'b0, '0, '0, '0);
        check("tri z_o", 32'(z_o), 32'h000);
        check("tri tri_o", 32'(tri_o), 32'd1);
        check("tri err_o", 32'(err_o), 32'b111);

        // Saturation, clear with accept, reset while holding
        clr_i = 1'b1;
        step();
        clr_i     = 1'b0;
        cnt_sel_i = 2'd0;
        drive(1'b1, 10'h155, 10'h0AA, 10'h0AA);
        repeat (20) step();
        check("sat ori cnt", 32'(cnt_o), 32'd15);
        check("sat fault", 32'(fault_o), 32'b001);
        drive(1'b1, 10'h2A5, 10'h2A5, 10'h2A5);
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
        drive(1'b0, '0, '0, '0);
        out_ready = 1'b0;
        check("clr out_valid", 32'(out_valid), 32'd1);
        check("clr z_o", 32'(z_o), 32'h2A5);
        check("clr fault", 32'(fault_o), 32'b000);
        check_all_cnt_zero("clr cnt");
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst drops out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;

        // Random traffic; one replica at a time is made flaky to exercise faults
        for (int i = 0; i < 3000; i++) begin
            int mode;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            clr_i     = ($urandom_range(0, 60) == 0);
            rst       = ($urandom_range(0, 400) == 0);
            cnt_sel_i = 2'($urandom_range(0, 3));
            o    = W'($urandom);
            a    = o;
            n    = o;
            mode = int'($urandom_range(0, 5));
            case (mode)
                0: a = o ^ W'(1 << $urandom_range(0, W - 1));
                1: n = o ^ W'(1 << $urandom_range(0, W - 1));
                2: o = o ^ W'(1 << $urandom_range(0, W - 1));
                3: begin a = W'($urandom); n = W'($urandom); end
                4: if (i % 200 < 100) a = ~o;
                default: ;
            endcase
            ori_i = o;
            mai_i = a;
            men_i = n;
            step();
        end
        rst = 1'b0;
        clr_i = 1'b0;
        drive(1'b0, '0, '0, '0);
        out_ready = 1'b1;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
